// File: rtl/uplink_tx.sv
// Uplink transmitter: queues 5-bit keycodes and serialises each as the redundant
// word {K, ~K, K}, one UPL1 (one) or UPL0 (zero) pulse per bit, MSB first.
module uplink_tx #(
   parameter int PULSE_CYC  = 50,
   parameter int BIT_CYC    = 500,
   parameter int WORD_GAP   = 5000,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          SIM_CLK,
   input  logic                          SIM_RST_n,
   input  logic [4:0]                    key_data,
   input  logic                          key_valid,
   output logic                          key_ready,
   input  logic                          flush,
   input  logic                          BLKUPL_n,
   output logic                          UPL0,
   output logic                          UPL1,
   output logic                          busy,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
   localparam int AW   = $clog2(FIFO_DEPTH);
   localparam int LW   = AW + 1;
   localparam int CMAX = (BIT_CYC > WORD_GAP) ? BIT_CYC : WORD_GAP;
   localparam int CW   = $clog2(CMAX + 1);
   localparam logic [CW-1:0] P_LAST = CW'(PULSE_CYC - 1);
   localparam logic [CW-1:0] S_LAST = CW'(BIT_CYC - PULSE_CYC - 1);
   localparam logic [CW-1:0] G_LAST = CW'(WORD_GAP - 1);

   typedef enum logic [1:0] {IDLE, PULSE, SPACE, WGAP} state_t;

   state_t          state;
   logic [CW-1:0]   cnt;
   logic [3:0]      bits;
   logic [14:0]     sh;
   logic [4:0]      mem [FIFO_DEPTH];
   logic [AW-1:0]   wr_ptr, rd_ptr;
   logic [LW-1:0]   level;
   logic [4:0]      head;
   logic            push, launch;

   assign key_ready  = (level != LW'(FIFO_DEPTH));
   assign fifo_level = level;
   assign busy       = (state != IDLE);
   assign head       = mem[rd_ptr];
   assign push       = key_valid & key_ready & ~flush;

   // The last WGAP cycle makes the IDLE decision itself, so a queued word
   // follows the gap without an extra idle cycle.
   assign launch = (level != '0) & BLKUPL_n & ~flush &
                   ((state == IDLE) | ((state == WGAP) & (cnt == G_LAST)));

   always_ff @(posedge SIM_CLK)
      if (push) mem[wr_ptr] <= key_data;

   always_ff @(posedge SIM_CLK or negedge SIM_RST_n) begin
      if (!SIM_RST_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push)   wr_ptr <= wr_ptr + AW'(1);
         if (launch) rd_ptr <= rd_ptr + AW'(1);
         case ({push, launch})
            2'b10:   level <= level + LW'(1);
            2'b01:   level <= level - LW'(1);
            default: level <= level;
         endcase
      end
   end

   always_ff @(posedge SIM_CLK or negedge SIM_RST_n) begin
      if (!SIM_RST_n) begin
         state <= IDLE;
         cnt   <= '0;
         bits  <= '0;
         sh    <= '0;
         UPL0  <= 1'b0;
         UPL1  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (launch) begin
                  sh    <= {head, ~head, head};
                  bits  <= 4'd15;
                  cnt   <= '0;
                  state <= PULSE;
               end
            end
            PULSE: begin
               if (flush) begin
                  UPL0  <= 1'b0;
                  UPL1  <= 1'b0;
                  cnt   <= '0;
                  state <= WGAP;
               end else begin
                  UPL1 <= sh[14];
                  UPL0 <= ~sh[14];
                  if (cnt == P_LAST) begin
                     cnt   <= '0;
                     state <= SPACE;
                  end else begin
                     cnt <= cnt + CW'(1);
                  end
               end
            end
            SPACE: begin
               UPL0 <= 1'b0;
               UPL1 <= 1'b0;
               if (flush) begin
                  cnt   <= '0;
                  state <= WGAP;
               end else if (cnt == S_LAST) begin
                  cnt   <= '0;
                  sh    <= {sh[13:0], 1'b0};
                  bits  <= bits - 4'd1;
                  state <= (bits == 4'd1) ? WGAP : PULSE;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            WGAP: begin
               if (cnt == G_LAST) begin
                  cnt <= '0;
                  if (launch) begin
                     sh    <= {head, ~head, head};
                     bits  <= 4'd15;
                     state <= PULSE;
                  end else begin
                     state <= IDLE;
                  end
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
